rock_scheduler: RTL
===================

ROCK_SCHEDULER -- requirements
Module: rock_scheduler

Interface
REQ-001 SHALL have parameter LANE0_X, default 10'd160, meaning lane 0 rock X center.
REQ-002 SHALL have parameter LANE1_X, default 10'd320, meaning lane 1 rock X center.
REQ-003 SHALL have parameter LANE2_X, default 10'd480, meaning lane 2 rock X center.
REQ-004 SHALL have parameter SPAWN_GAP, default 8'd45, meaning frames between spawn attempts.
REQ-005 SHALL have parameter SEED, default 16'hACE1, meaning LFSR reset value (nonzero).
REQ-006 SHALL have port clk, input, 1 bit, the single clock.
REQ-007 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have port frame_tick, input, 1 bit, one-cycle pulse per frame.
REQ-009 SHALL have port run, input, 1 bit, game active.
REQ-010 SHALL have port clear, input, 1 bit, flush all rocks.
REQ-011 SHALL have port speed, input, 3 bits, pixels moved per frame.
REQ-012 SHALL have ports hCount and vCount, inputs, 10 bits each, current VGA pixel.
REQ-013 SHALL have ports rock_x_center and rock_y_top, outputs, 10 bits each, selected rock position for the rock renderer.
REQ-014 SHALL have port rock_sel_valid, output, 1 bit, a rock covers the pixel.
REQ-015 SHALL have port slot_active, output, 4 bits, per-slot occupancy.
REQ-016 SHALL have port spawn_pulse, output, 1 bit, one-cycle pulse on each spawn.
REQ-017 SHALL have port state, output, 2 bits: IDLE=0, PLAY=1, FREEZE=2.

Function
REQ-018 SHALL hold 4 slots, each with active bit, lane (0..2) and y_top (10 bits).
REQ-019 FSM SHALL go IDLE->PLAY when run=1, PLAY->FREEZE when run=0, FREEZE->PLAY when run=1, and any state->IDLE when clear=1 (clear has priority).
REQ-020 clear SHALL free all slots and reload the spawn counter to SPAWN_GAP in the same cycle.
REQ-021 In PLAY on frame_tick, each active slot SHALL move y_top += speed (effective); if y_top+speed >= 480, the slot SHALL become inactive instead.
REQ-022 Spawn counter SHALL decrement on each PLAY frame_tick and saturate at 0.
REQ-023 On a PLAY frame_tick with counter==0 and a free slot: spawn into the lowest-index free slot with y_top=0, reload counter to SPAWN_GAP, pulse spawn_pulse.
REQ-024 With counter==0 and no free slot, SHALL hold counter at 0 and retry on the next frame_tick.
REQ-025 A slot spawned on a tick SHALL NOT also move on that tick; a slot retiring on a tick SHALL NOT be reused on that tick.
REQ-026 The LFSR SHALL be a 16-bit Galois LFSR (mask 16'hB400) stepping on every PLAY frame_tick.
REQ-027 Spawn lane SHALL be lfsr[1:0], with value 3 mapped to lane 1.
REQ-028 In FREEZE and IDLE, positions, counter and LFSR SHALL hold.
REQ-029 Pixel select: among active slots whose box (x_center-40 <= hCount < x_center+40, y_top <= vCount < y_top+80) covers the pixel, pick the lowest index.
REQ-030 rock_x_center, rock_y_top and rock_sel_valid SHALL be registered with 1-cycle latency from hCount/vCount.
REQ-031 With no hit, rock_sel_valid=0 and the position outputs SHALL hold their last value.

Reset
REQ-032 On rst: state=IDLE, all slots inactive, slot_active=0, counter=SPAWN_GAP, LFSR=SEED, spawn_pulse=0, rock_sel_valid=0, rock_x_center=0, rock_y_top=0.
REQ-033 rst asserted mid-frame SHALL take effect next edge and override clear, run and frame_tick.

Configuration
REQ-034 With ROCK_SPEEDUP_EN defined: effective speed = speed + (spawn count / 8), saturated at 7; the spawn count is 6 bits, saturating, and cleared by rst and clear.
REQ-035 Without ROCK_SPEEDUP_EN: effective speed = speed, and no spawn count is present.

Verification
REQ-036 rst, then run=1, SPAWN_GAP=2, 3 ticks -> spawn_pulse on the 3rd tick, slot_active=4'b0001, y_top=0.
REQ-037 Slot at y_top=476 with speed=4, one tick -> slot freed (476+4=480); at y_top=475 -> y_top=479.
REQ-038 All 4 slots active with counter=0, two ticks -> no spawn and counter stays 0; free slot 2 -> next tick spawns into slot 2.
REQ-039 Slots 0 and 1 both at lane 1 (x=320), y_top=100, pixel (320,150) -> one cycle later rock_sel_valid=1 and slot 0's position is output.
REQ-040 run=0 mid-game, 5 ticks -> state=FREEZE and positions unchanged; clear -> state=IDLE and slot_active=0.
REQ-041 With ROCK_SPEEDUP_EN, speed=6, after 16 spawns -> effective speed 7 (saturated).

Source files
------------

// File: rtl/rock_scheduler.sv
// rock_scheduler: spawns falling rocks into three lanes, moves them once per
// frame and picks the rock covering the current VGA pixel for the renderer.
// Optional feature macro: ROCK_SPEEDUP_EN. When defined, the fall speed grows
// with the number of spawns since reset/clear (speed + spawns/8, capped at 7).
module rock_scheduler #(
  parameter logic [9:0]  LANE0_X   = 10'd160,
  parameter logic [9:0]  LANE1_X   = 10'd320,
  parameter logic [9:0]  LANE2_X   = 10'd480,
  parameter logic [7:0]  SPAWN_GAP = 8'd45,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       run,
  input  logic       clear,
  input  logic [2:0] speed,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  output logic [9:0] rock_x_center,
  output logic [9:0] rock_y_top,
  output logic       rock_sel_valid,
  output logic [3:0] slot_active,
  output logic       spawn_pulse,
  output logic [1:0] state
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, FREEZE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        play_tick;
  logic [3:0]  active_q, active_d;
  logic [1:0]  lane_q [4];
  logic [1:0]  lane_d [4];
  logic [9:0]  ytop_q [4];
  logic [9:0]  ytop_d [4];
  logic [10:0] step_sum [4];
  logic [7:0]  cnt_q;
  logic [15:0] lfsr_q;
  logic [1:0]  free_idx;
  logic        spawn_go;
  logic [1:0]  spawn_lane;
  logic [2:0]  eff_speed;
  logic        hit;
  logic [9:0]  hit_x, hit_y;

  function automatic logic [9:0] lane_x(input logic [1:0] lane);
    case (lane)
      2'd0:    lane_x = LANE0_X;
      2'd2:    lane_x = LANE2_X;
      default: lane_x = LANE1_X;
    endcase
  endfunction

  assign state       = state_q;
  assign slot_active = active_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; clear wins over run
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (run)  state_d = PLAY;
        PLAY:    if (!run) state_d = FREEZE;
        FREEZE:  if (run)  state_d = PLAY;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM output: a frame tick that advances the game
  always_comb begin
    play_tick = (state_q == PLAY) && frame_tick && !clear;
  end

`ifdef ROCK_SPEEDUP_EN
  logic [5:0] spawn_cnt_q;
  logic [3:0] boosted;

  // Spawn count since reset/clear, saturating at 63
  always_ff @(posedge clk) begin
    if (rst || clear)                      spawn_cnt_q <= '0;
    else if (spawn_go && spawn_cnt_q != '1) spawn_cnt_q <= spawn_cnt_q + 6'd1;
  end

  // Effective speed = speed + spawns/8, capped at 7
  always_comb begin
    boosted   = {1'b0, speed} + {1'b0, spawn_cnt_q[5:3]};
    eff_speed = (boosted > 4'd7) ? 3'd7 : boosted[2:0];
  end
`else
  // Effective speed is the raw speed input
  always_comb begin
    eff_speed = speed;
  end
`endif

  // Spawn decision: lowest free slot taken from occupancy before this tick,
  // so a slot retiring on this tick cannot be refilled on the same tick
  always_comb begin
    free_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!active_q[i]) free_idx = 2'(i);
    end
    spawn_go   = play_tick && (cnt_q == 8'd0) && !(&active_q);
    spawn_lane = (lfsr_q[1:0] == 2'd3) ? 2'd1 : lfsr_q[1:0];
  end

  // Next slot contents: move or retire active slots, then place the new rock
  always_comb begin
    active_d = active_q;
    for (int i = 0; i < 4; i++) begin
      lane_d[i]   = lane_q[i];
      ytop_d[i]   = ytop_q[i];
      step_sum[i] = {1'b0, ytop_q[i]} + {8'd0, eff_speed};
      if (play_tick && active_q[i]) begin
        if (step_sum[i] >= 11'd480) active_d[i] = 1'b0;
        else                         ytop_d[i]   = step_sum[i][9:0];
      end
    end
    if (spawn_go) begin
      active_d[free_idx] = 1'b1;
      lane_d[free_idx]   = spawn_lane;
      ytop_d[free_idx]   = 10'd0;
    end
  end

  // Slot storage, spawn counter, LFSR and spawn pulse
  always_ff @(posedge clk) begin
    // NOTE: the slot array is only four entries, so every field is reset to
    // keep the outputs deterministic even though only the active bits matter.
    if (rst) begin
      active_q    <= '0;
      cnt_q       <= SPAWN_GAP;
      lfsr_q      <= SEED;
      spawn_pulse <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        lane_q[i] <= 2'd0;
        ytop_q[i] <= 10'd0;
      end
    end else if (clear) begin
      active_q    <= '0;
      cnt_q       <= SPAWN_GAP;
      spawn_pulse <= 1'b0;
    end else begin
      active_q    <= active_d;
      spawn_pulse <= spawn_go;
      for (int i = 0; i < 4; i++) begin
        lane_q[i] <= lane_d[i];
        ytop_q[i] <= ytop_d[i];
      end
      if (play_tick) begin
        if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
        else if (spawn_go) cnt_q <= SPAWN_GAP;
        lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
      end
    end
  end

  // Pixel hit test; scanning downward leaves the lowest-index hit selected
  always_comb begin
    hit   = 1'b0;
    hit_x = rock_x_center;
    hit_y = rock_y_top;
    for (int i = 3; i >= 0; i--) begin
      if (active_q[i] &&
          ({1'b0, lane_x(lane_q[i])} <= {1'b0, hCount} + 11'd40) &&
          ({1'b0, hCount} < {1'b0, lane_x(lane_q[i])} + 11'd40) &&
          (vCount >= ytop_q[i]) &&
          ({1'b0, vCount} < {1'b0, ytop_q[i]} + 11'd80)) begin
        hit   = 1'b1;
        hit_x = lane_x(lane_q[i]);
        hit_y = ytop_q[i];
      end
    end
  end

  // Registered renderer outputs; positions hold when nothing is hit
  always_ff @(posedge clk) begin
    if (rst) begin
      rock_sel_valid <= 1'b0;
      rock_x_center  <= 10'd0;
      rock_y_top     <= 10'd0;
    end else begin
      rock_sel_valid <= hit;
      rock_x_center  <= hit_x;
      rock_y_top     <= hit_y;
    end
  end

endmodule
